// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LOAD_OP_W  = 3;

    localparam logic [LOAD_OP_W-1:0] LB  = 3'b000;
    localparam logic [LOAD_OP_W-1:0] LH  = 3'b001;
    localparam logic [LOAD_OP_W-1:0] LW  = 3'b010;
    localparam logic [LOAD_OP_W-1:0] LBU = 3'b100;
    localparam logic [LOAD_OP_W-1:0] LHU = 3'b101;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
        logic [LOAD_OP_W-1:0]  load_op;
        logic                  is_load;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back producer handshakes and the register-file write-port controls.
interface regfile_wb_arbiter_if;
    import regfile_pkg::*;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0]     alu_data;

    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [REG_ADDR_W-1:0] lsu_rd;
    logic [DATA_W-1:0]     lsu_data;
    logic [LOAD_OP_W-1:0]  lsu_load_op;

    logic                  rf_write_enable;
    logic [REG_ADDR_W-1:0] rf_write_address;
    logic [DATA_W-1:0]     rf_write_data;
    logic                  rf_mem_read_enable;
    logic [LOAD_OP_W-1:0]  rf_load_operation;
    logic [DATA_W-1:0]     rf_mem_read_data;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data, lsu_load_op,
        input  alu_ready, lsu_ready,
        input  rf_write_enable, rf_write_address, rf_write_data,
        input  rf_mem_read_enable, rf_load_operation, rf_mem_read_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data, lsu_load_op,
        output alu_ready, lsu_ready,
        output rf_write_enable, rf_write_address, rf_write_data,
        output rf_mem_read_enable, rf_load_operation, rf_mem_read_data
    );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Per-register outstanding-write counters for RAW stall detection (x0 never tracked).
module wb_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned PEND_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_addr
);

    localparam int unsigned NumRegs = 1 << REG_ADDR_W;
    localparam logic [PEND_W-1:0] CntMax = '1;

    logic [PEND_W-1:0] cnt_q [NumRegs];
    logic [PEND_W-1:0] cnt_d [NumRegs];
    logic              inc_valid;

    // A full counter can still take an issue when the same edge retires a write to it.
    assign issue_ready = (issue_rd == '0) || (cnt_q[issue_rd] != CntMax) ||
                         (dec_valid && (dec_addr == issue_rd));
    assign inc_valid   = issue_valid && issue_ready && (issue_rd != '0);

    assign rs1_busy = (cnt_q[rs1_addr] != '0);
    assign rs2_busy = (cnt_q[rs2_addr] != '0);

    always_comb begin
        cnt_d[0] = '0;
        for (int unsigned i = 1; i < NumRegs; i++) begin
            cnt_d[i] = cnt_q[i];
            if (inc_valid && (issue_rd == REG_ADDR_W'(i))) begin
                if (!(dec_valid && (dec_addr == REG_ADDR_W'(i)))) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (dec_valid && (dec_addr == REG_ADDR_W'(i)) && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Retiring a write that was never issued is a producer protocol error.
    always_ff @(posedge clk) begin
        if (reset && dec_valid) begin
            assert (cnt_q[dec_addr] != '0);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load write-back onto the single register-file write port.
// Macro WB_RR_ARB_EN swaps LSU priority + starvation override for a round-robin pointer.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned PEND_W       = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    regfile_wb_arbiter_if.slave   wb
);

    wb_req_t alu_q, alu_d, lsu_q, lsu_d, out_q, out_d;
    logic    alu_full_q, alu_full_d, lsu_full_q, lsu_full_d;
    logic    out_we_q, out_we_d;
    logic    grant_alu, grant_lsu;
    logic    alu_ready, lsu_ready;

`ifdef WB_RR_ARB_EN
    logic rr_q, rr_d;

    // rr_q=0 favours the LSU; flip only when both sides actually contended.
    always_comb begin
        grant_alu = alu_full_q && (!lsu_full_q || rr_q);
        grant_lsu = lsu_full_q && !grant_alu;
        rr_d      = rr_q;
        if (alu_full_q && lsu_full_q) begin
            rr_d = ~rr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    logic [StarveW-1:0] starve_q, starve_d;

    always_comb begin
        grant_alu = alu_full_q && (!lsu_full_q || (starve_q == StarveW'(STARVE_LIMIT)));
        grant_lsu = lsu_full_q && !grant_alu;
        starve_d  = '0;
        if (alu_full_q && !grant_alu) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // An entry being granted this cycle frees up in time to take a new beat.
    assign alu_ready    = !alu_full_q || grant_alu;
    assign lsu_ready    = !lsu_full_q || grant_lsu;
    assign wb.alu_ready = alu_ready;
    assign wb.lsu_ready = lsu_ready;

    always_comb begin
        alu_full_d = alu_full_q && !grant_alu;
        alu_d      = alu_q;
        if (wb.alu_valid && alu_ready) begin
            alu_full_d = 1'b1;
            alu_d      = '{rd: wb.alu_rd, data: wb.alu_data, load_op: '0, is_load: 1'b0};
        end
        lsu_full_d = lsu_full_q && !grant_lsu;
        lsu_d      = lsu_q;
        if (wb.lsu_valid && lsu_ready) begin
            lsu_full_d = 1'b1;
            lsu_d      = '{rd: wb.lsu_rd, data: wb.lsu_data, load_op: wb.lsu_load_op,
                           is_load: 1'b1};
        end
    end

    // Idle cycles drop the enable but keep the remaining write-port fields stable.
    always_comb begin
        out_d    = out_q;
        out_we_d = 1'b0;
        if (grant_lsu) begin
            out_d    = lsu_q;
            out_we_d = (lsu_q.rd != '0);
        end else if (grant_alu) begin
            out_d    = alu_q;
            out_we_d = (alu_q.rd != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_full_q <= 1'b0;
            lsu_full_q <= 1'b0;
            alu_q      <= '0;
            lsu_q      <= '0;
            out_q      <= '0;
            out_we_q   <= 1'b0;
        end else begin
            alu_full_q <= alu_full_d;
            lsu_full_q <= lsu_full_d;
            alu_q      <= alu_d;
            lsu_q      <= lsu_d;
            out_q      <= out_d;
            out_we_q   <= out_we_d;
        end
    end

    always_comb begin
        wb.rf_write_enable    = out_we_q;
        wb.rf_write_address   = out_q.rd;
        wb.rf_mem_read_enable = out_q.is_load;
        wb.rf_write_data      = out_q.is_load ? '0 : out_q.data;
        wb.rf_mem_read_data   = out_q.is_load ? out_q.data : '0;
        wb.rf_load_operation  = out_q.is_load ? out_q.load_op : '0;
    end

    wb_scoreboard #(
        .PEND_W (PEND_W)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .dec_valid   (out_we_q),
        .dec_addr    (out_q.rd)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter (default or WB_RR_ARB_EN build).
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       issue_ready;
    logic [4:0] rs1_addr, rs2_addr;
    logic       rs1_busy, rs2_busy;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if wb ();

    regfile_wb_arbiter #(
        .PEND_W       (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .wb          (wb)
    );

    // Stimulus: iv ird rs1 rs2 av ard ad lv lrd ld lop
    // Expected: we addr wd mre elop mrd (rf fields checked only when we=1) ar lr ir b1 b2
    typedef struct {
        int iv, ird, rs1, rs2, av, ard, ad, lv, lrd, ld, lop;
        int we, addr, wd, mre, elop, mrd, ar, lr, ir, b1, b2;
    } vec_t;

    vec_t tbl[$];

    task automatic drive_idle();
        issue_valid    = 1'b0;
        issue_rd       = '0;
        rs1_addr       = '0;
        rs2_addr       = '0;
        wb.alu_valid   = 1'b0;
        wb.alu_rd      = '0;
        wb.alu_data    = '0;
        wb.lsu_valid   = 1'b0;
        wb.lsu_rd      = '0;
        wb.lsu_data    = '0;
        wb.lsu_load_op = '0;
    endtask

    task automatic apply(input vec_t v, input string name);
        logic ok;
        @(negedge clk);
        issue_valid    = 1'(v.iv);
        issue_rd       = 5'(v.ird);
        rs1_addr       = 5'(v.rs1);
        rs2_addr       = 5'(v.rs2);
        wb.alu_valid   = 1'(v.av);
        wb.alu_rd      = 5'(v.ard);
        wb.alu_data    = 32'(v.ad);
        wb.lsu_valid   = 1'(v.lv);
        wb.lsu_rd      = 5'(v.lrd);
        wb.lsu_data    = 32'(v.ld);
        wb.lsu_load_op = 3'(v.lop);
        #1;
        n_vec++;
        ok = (wb.rf_write_enable == 1'(v.we)) && (wb.alu_ready == 1'(v.ar)) &&
             (wb.lsu_ready == 1'(v.lr)) && (issue_ready == 1'(v.ir)) &&
             (rs1_busy == 1'(v.b1)) && (rs2_busy == 1'(v.b2));
        if (v.we != 0) begin
            ok = ok && (wb.rf_write_address == 5'(v.addr)) && (wb.rf_write_data == 32'(v.wd)) &&
                 (wb.rf_mem_read_enable == 1'(v.mre)) && (wb.rf_load_operation == 3'(v.elop)) &&
                 (wb.rf_mem_read_data == 32'(v.mrd));
        end
        if (!ok) begin
            n_miss++;
            $display("FAIL %s: got we=%0b addr=%0d wd=%h mre=%0b lop=%0d mrd=%h ar=%0b lr=%0b ir=%0b b1=%0b b2=%0b; want we=%0d addr=%0d wd=%h mre=%0d lop=%0d mrd=%h ar=%0d lr=%0d ir=%0d b1=%0d b2=%0d",
                     name, wb.rf_write_enable, wb.rf_write_address, wb.rf_write_data,
                     wb.rf_mem_read_enable, wb.rf_load_operation, wb.rf_mem_read_data,
                     wb.alu_ready, wb.lsu_ready, issue_ready, rs1_busy, rs2_busy,
                     v.we, v.addr, v.wd, v.mre, v.elop, v.mrd, v.ar, v.lr, v.ir, v.b1, v.b2);
        end
    endtask

    // Samples only: all rf_* zero, every ready high, nothing busy.
    task automatic check_reset_state(input string name);
        n_vec++;
        if (wb.rf_write_enable !== 1'b0 || wb.rf_write_address !== '0 ||
            wb.rf_write_data !== '0 || wb.rf_mem_read_enable !== 1'b0 ||
            wb.rf_load_operation !== '0 || wb.rf_mem_read_data !== '0 ||
            wb.alu_ready !== 1'b1 || wb.lsu_ready !== 1'b1 || issue_ready !== 1'b1 ||
            rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            n_miss++;
            $display("FAIL %s: got we=%0b addr=%0d wd=%h mre=%0b lop=%0d mrd=%h ar=%0b lr=%0b ir=%0b b1=%0b b2=%0b; want all rf zero, readys 1, busy 0",
                     name, wb.rf_write_enable, wb.rf_write_address, wb.rf_write_data,
                     wb.rf_mem_read_enable, wb.rf_load_operation, wb.rf_mem_read_data,
                     wb.alu_ready, wb.lsu_ready, issue_ready, rs1_busy, rs2_busy);
        end
    endtask

    task automatic issue_regs(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            issue_valid = 1'b1;
            issue_rd    = 5'(first + i);
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        int got_addr[$];
        int exp_addr[12];
        int ln;
        int an;

        drive_idle();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_state("reset_state");

        // Plan 1: ALU write-back lands two edges after the handshake.
        tbl.push_back('{1,3,3,0, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,0,0});
        tbl.push_back('{0,0,3,0, 1,3,'h1234, 0,0,0,0,   0,0,0,0,0,0,       1,1,1,1,0});
        tbl.push_back('{0,0,3,0, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,1,0});
        tbl.push_back('{0,0,3,0, 0,0,0, 0,0,0,0,        1,3,'h1234,0,0,0,  1,1,1,1,0});
        tbl.push_back('{0,0,3,0, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,0,0});
        // Plan 3: three issues to x5 fill the counter; a same-edge retire reopens it.
        tbl.push_back('{1,5,5,0, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,0,0});
        tbl.push_back('{1,5,5,0, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,1,0});
        tbl.push_back('{1,5,5,0, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,1,0});
        tbl.push_back('{1,5,5,0, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,0,1,0});
        tbl.push_back('{1,5,5,0, 1,5,'hA1, 0,0,0,0,     0,0,0,0,0,0,       1,1,0,1,0});
        tbl.push_back('{0,0,5,0, 1,5,'hA2, 0,0,0,0,     0,0,0,0,0,0,       1,1,1,1,0});
        tbl.push_back('{1,5,5,0, 1,5,'hA3, 0,0,0,0,     1,5,'hA1,0,0,0,    1,1,1,1,0});
        tbl.push_back('{0,0,5,0, 1,5,'hA4, 0,0,0,0,     1,5,'hA2,0,0,0,    1,1,1,1,0});
        tbl.push_back('{0,0,5,0, 0,0,0, 0,0,0,0,        1,5,'hA3,0,0,0,    1,1,1,1,0});
        tbl.push_back('{0,0,5,0, 0,0,0, 0,0,0,0,        1,5,'hA4,0,0,0,    1,1,1,1,0});
        tbl.push_back('{0,0,5,0, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,0,0});
        // Plan 4: issue and retire of x7 on the same edge leaves it busy.
        tbl.push_back('{1,7,0,7, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,0,0});
        tbl.push_back('{0,0,0,7, 1,7,'h77, 0,0,0,0,     0,0,0,0,0,0,       1,1,1,0,1});
        tbl.push_back('{0,0,0,7, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,0,1});
        tbl.push_back('{1,7,0,7, 0,0,0, 0,0,0,0,        1,7,'h77,0,0,0,    1,1,1,0,1});
        tbl.push_back('{0,0,0,7, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,0,1});
        tbl.push_back('{0,0,0,7, 1,7,'h78, 0,0,0,0,     0,0,0,0,0,0,       1,1,1,0,1});
        tbl.push_back('{0,0,0,7, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,0,1});
        tbl.push_back('{0,0,0,7, 0,0,0, 0,0,0,0,        1,7,'h78,0,0,0,    1,1,1,0,1});
        tbl.push_back('{0,0,0,7, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,0,0});
        // Plan 5: load to x0 is consumed silently; then a real LHU to x9.
        tbl.push_back('{0,0,0,0, 0,0,0, 1,0,'hDEADBEEF,0, 0,0,0,0,0,0,     1,1,1,0,0});
        tbl.push_back('{0,0,0,0, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,0,0});
        tbl.push_back('{0,0,0,0, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,0,0});
        tbl.push_back('{0,0,0,0, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,0,0});
        tbl.push_back('{1,9,9,0, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,0,0});
        tbl.push_back('{0,0,9,0, 0,0,0, 1,9,'h80FF1234,5, 0,0,0,0,0,0,     1,1,1,1,0});
        tbl.push_back('{0,0,9,0, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,1,0});
        tbl.push_back('{0,0,9,0, 0,0,0, 0,0,0,0,        1,9,0,1,5,'h80FF1234, 1,1,1,1,0});
        tbl.push_back('{0,0,9,0, 0,0,0, 0,0,0,0,        0,0,0,0,0,0,       1,1,1,0,0});

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Plan 2: both producers stream; record the order of write addresses.
        issue_regs(10, 12);
`ifdef WB_RR_ARB_EN
        exp_addr = '{10, 20, 11, 21, 12, 13, 14, 15, 16, 17, 18, 19};
`else
        exp_addr = '{10, 11, 12, 13, 20, 14, 15, 16, 17, 21, 18, 19};
`endif
        ln = 0;
        an = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            wb.lsu_valid   = (ln < 10);
            wb.lsu_rd      = 5'(10 + ln);
            wb.lsu_data    = 32'(ln);
            wb.lsu_load_op = LW;
            wb.alu_valid   = (an < 2);
            wb.alu_rd      = 5'(20 + an);
            wb.alu_data    = 32'(100 + an);
            #1;
            if (wb.rf_write_enable) got_addr.push_back(int'(wb.rf_write_address));
            if (wb.lsu_valid && wb.lsu_ready) ln++;
            if (wb.alu_valid && wb.alu_ready) an++;
        end
        drive_idle();
        n_vec++;
        if (got_addr.size() != 12) begin
            n_miss++;
            $display("FAIL arb_write_count: got %0d writes, want 12", got_addr.size());
        end
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (i >= got_addr.size() || got_addr[i] != exp_addr[i]) begin
                n_miss++;
                $display("FAIL arb_order[%0d]: got addr=%0d, want %0d", i,
                         (i < got_addr.size()) ? got_addr[i] : -1, exp_addr[i]);
            end
        end

        // Plan 6: reset while both holding entries are full.
        issue_regs(25, 2);
        @(negedge clk);
        rs1_addr       = 5'd25;
        rs2_addr       = 5'd26;
        wb.alu_valid   = 1'b1;
        wb.alu_rd      = 5'd25;
        wb.alu_data    = 32'h1;
        wb.lsu_valid   = 1'b1;
        wb.lsu_rd      = 5'd26;
        wb.lsu_data    = 32'h2;
        wb.lsu_load_op = LW;
        @(negedge clk);
        wb.alu_valid = 1'b0;
        wb.lsu_valid = 1'b0;
        reset        = 1'b0;
        #1;
        n_vec++;
        if (!(rs1_busy && rs2_busy && !wb.alu_ready && wb.lsu_ready)) begin
            n_miss++;
            $display("FAIL pre_reset_full: got b1=%0b b2=%0b ar=%0b lr=%0b, want 1 1 0 1",
                     rs1_busy, rs2_busy, wb.alu_ready, wb.lsu_ready);
        end
        @(negedge clk);
        #1;
        check_reset_state("reset_hold");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_state("post_reset_1");
        @(negedge clk);
        #1;
        check_reset_state("post_reset_2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sequences the single write port of the 32x32 register file between two producers: the ALU write-back and the load unit.
- Drives the register file's write-port controls: write enable, address, data, mem-read select and load operation.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards.
- Sits between the execute/memory stages and the register file.

Parameters:
- PEND_W, 2, width of each per-register outstanding-write counter (max 2^PEND_W-1 in flight per rd).
- STARVE_LIMIT, 4, consecutive cycles an ALU beat may lose arbitration before it is forced to win.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (sampled on rising clk).
- issue_valid  in  1  decode issues an instruction that will write rd.
- issue_rd  in  5  destination of the issued instruction.
- issue_ready  out  1  scoreboard can accept the issue.
- rs1_addr, rs2_addr  in  5 each  decode source addresses.
- rs1_busy, rs2_busy  out  1 each  source has an outstanding write.
- alu_valid / alu_ready  in / out  1 / 1  ALU write-back handshake.
- alu_rd  in  5  ALU destination.
- alu_data  in  32  ALU result.
- lsu_valid / lsu_ready  in / out  1 / 1  load write-back handshake.
- lsu_rd  in  5  load destination.
- lsu_data  in  32  raw memory word.
- lsu_load_op  in  3  LB=000, LH=001, LW=010, LBU=100, LHU=101.
- rf_write_enable  out  1  register-file write enable.
- rf_write_address  out  5  register-file write address.
- rf_write_data  out  32  ALU result.
- rf_mem_read_enable  out  1  selects the load path in the register file.
- rf_load_operation  out  3  load op passed through.
- rf_mem_read_data  out  32  raw load word.

Behaviour:
- Reset: all rf_* outputs are 0. Holding registers, starvation counter, round-robin pointer and all scoreboard counters are 0. issue_ready=1, alu_ready=1, lsu_ready=1, rs*_busy=0.
- Holding stage: one entry per requester.
  - ready = !full || (granted this cycle).
  - valid && ready at edge k loads the entry.
- Arbitration: combinational over full entries.
  - Default: LSU wins over ALU.
  - ALU wins if its starvation count == STARVE_LIMIT.
  - Starvation count increments each cycle the ALU entry is full and loses; it clears when the ALU wins or its entry is empty.
- Output stage: registered.
  - The winner is granted in cycle k+1 and drives rf_* in cycle k+1..k+2.
  - The register file writes at edge k+2, so latency from handshake to write is 2 edges.
  - Throughput: one write per cycle.
- Path selection:
  - LSU winner: rf_mem_read_enable=1, rf_load_operation=lsu_load_op, rf_mem_read_data=lsu_data, rf_write_data=0.
  - ALU winner: rf_mem_read_enable=0, rf_write_data=alu_data, rf_load_operation=0, rf_mem_read_data=0.
- No grant in a cycle: rf_write_enable=0 next cycle; the other rf_* fields hold their last values.
- rd==0 beats: accepted and granted, but rf_write_enable stays 0 and no scoreboard decrement occurs.
- Scoreboard, one counter per register (x0 excluded):
  - Increment on an issue_valid && issue_ready handshake with issue_rd!=0.
  - Decrement at the edge where rf_write_enable=1 for that address.
  - Increment and decrement of the same register at the same edge: counter unchanged.
  - issue_ready=0 only when cnt[issue_rd] is at max and no decrement of issue_rd occurs at this edge.
  - issue_rd==0: always ready, never counted.
  - rsN_busy = (cnt[rsN_addr]!=0), combinational. rsN_addr==0 gives 0.
- Decrement of a counter that is already zero is a protocol error. The counter stays at 0 (simulation assertion).
- Reset mid-operation: all in-flight beats are dropped and no write is issued the cycle after reset deasserts.

Optional Feature:
- Macro: WB_RR_ARB_EN.
- Defined: the fixed-priority/starvation scheme is replaced by a 1-bit round-robin pointer.
  - The pointer toggles to the other requester after each grant when both are full.
  - STARVE_LIMIT is unused.
- Undefined: LSU priority with the starvation override, as above.

Decomposition:
- Package regfile_pkg holds:
  - the load-op localparams LB/LH/LW/LBU/LHU;
  - the register address width (5) and data width (32);
  - a typedef wb_req_t {rd, data, load_op, is_load} used for holding entries and the output stage.
- One natural sub-module: wb_scoreboard, covering the counters, issue_ready and the busy outputs.

Test Plan:
1. Reset, then ALU beat rd=3, data=0x1234: rf_write_enable=1, rf_write_address=3, rf_write_data=0x1234, rf_mem_read_enable=0, exactly 2 edges after the handshake.
2. ALU and LSU both valid every cycle, LSU continuous (STARVE_LIMIT=4): ALU is granted on the 5th contending cycle, then the LSU resumes. Under WB_RR_ARB_EN, grants alternate LSU, ALU, LSU, ...
3. Issue rd=5 twice, then rs1_addr=5: rs1_busy=1 until the second write to x5. A third issue to rd=5 with PEND_W=2 is allowed; at count 3, issue_ready=0.
4. Same-edge issue to rd=7 and write-back of x7 with cnt=1: cnt stays 1 and rs2_busy (rs2_addr=7) stays 1.
5. LSU beat rd=0, lsu_load_op=LB: the beat is accepted, rf_write_enable stays 0, and lsu_ready returns to 1.
6. Reset asserted with both holding entries full: next cycle all rf_* are 0, all readys are 1, and rs*_busy=0.
